// File: rtl/gift_masked_sbox_layer_if.sv
// Bus between the masked GIFT S-box layer sequencer and its environment:
// state shares, S-box stage nibble ports and the PRNG handshake.
interface gift_masked_sbox_layer_if #(
    parameter int NIBBLES = 16,
    parameter int RND_W   = 8
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [4*NIBBLES-1:0] state1_in;
    logic [4*NIBBLES-1:0] state2_in;
    logic [4*NIBBLES-1:0] state3_in;
    logic [4*NIBBLES-1:0] state1_out;
    logic [4*NIBBLES-1:0] state2_out;
    logic [4*NIBBLES-1:0] state3_out;
    logic [3:0]           sb_in1;
    logic [3:0]           sb_in2;
    logic [3:0]           sb_in3;
    logic [3:0]           sb_out1;
    logic [3:0]           sb_out2;
    logic [3:0]           sb_out3;
    logic [RND_W-1:0]     rnd_in;
    logic                 rnd_req;
    logic [RND_W-1:0]     sb_rnd;

    modport master (
        input  start, state1_in, state2_in, state3_in,
        input  sb_out1, sb_out2, sb_out3, rnd_in,
        output busy, done, state1_out, state2_out, state3_out,
        output sb_in1, sb_in2, sb_in3, rnd_req, sb_rnd
    );

    modport slave (
        output start, state1_in, state2_in, state3_in,
        output sb_out1, sb_out2, sb_out3, rnd_in,
        input  busy, done, state1_out, state2_out, state3_out,
        input  sb_in1, sb_in2, sb_in3, rnd_req, sb_rnd
    );
endinterface

// File: rtl/gift_masked_sbox_layer.sv
// Nibble-serial sequencer for a 3-share masked GIFT S-box layer.
// Define SBOX_BUBBLE_EN to insert an all-zero cycle between consecutive issues.
module gift_masked_sbox_layer #(
    parameter int NIBBLES  = 16,
    parameter int SBOX_LAT = 1,
    parameter int RND_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    gift_masked_sbox_layer_if.master bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int DW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);
    localparam logic [DW-1:0] DRN_LAST = DW'(SBOX_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        st_q, st_d;
    logic [W-1:0]  sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
    logic [3:0]    sb1_q, sb1_d, sb2_q, sb2_d, sb3_q, sb3_d;
    logic          iss_q, iss_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] drn_q, drn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
    logic          tag_vld_q [SBOX_LAT];
    logic          tag_vld_d [SBOX_LAT];
    logic [CW-1:0] tag_idx_q [SBOX_LAT];
    logic [CW-1:0] tag_idx_d [SBOX_LAT];
`ifdef SBOX_BUBBLE_EN
    logic          ph_q, ph_d;   // 1 while the current RUN cycle presents a nibble
`endif

    always_comb begin
        st_d   = st_q;
        sh1_d  = sh1_q;
        sh2_d  = sh2_q;
        sh3_d  = sh3_q;
        sb1_d  = '0;
        sb2_d  = '0;
        sb3_d  = '0;
        iss_d  = 1'b0;
        cnt_d  = cnt_q;
        drn_d  = drn_q;
        busy_d = busy_q;
        done_d = 1'b0;
`ifdef SBOX_BUBBLE_EN
        ph_d   = ph_q;
`endif
        case (st_q)
            IDLE: begin
                if (bus.start) begin
                    st_d           = RUN;
                    {sh1_d, sb1_d} = {4'h0, bus.state1_in};
                    {sh2_d, sb2_d} = {4'h0, bus.state2_in};
                    {sh3_d, sb3_d} = {4'h0, bus.state3_in};
                    iss_d          = 1'b1;
                    cnt_d          = '0;
                    busy_d         = 1'b1;
`ifdef SBOX_BUBBLE_EN
                    ph_d           = 1'b1;
`endif
                end
            end
            RUN: begin
`ifdef SBOX_BUBBLE_EN
                if (ph_q) begin
                    ph_d = 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        st_d  = DRAIN;
                        drn_d = '0;
                    end
                end else begin
                    {sh1_d, sb1_d} = {4'h0, sh1_q};
                    {sh2_d, sb2_d} = {4'h0, sh2_q};
                    {sh3_d, sb3_d} = {4'h0, sh3_q};
                    iss_d          = 1'b1;
                    cnt_d          = cnt_q + CW'(1);
                    ph_d           = 1'b1;
                end
`else
                if (cnt_q == CNT_LAST) begin
                    st_d  = DRAIN;
                    drn_d = '0;
                end else begin
                    {sh1_d, sb1_d} = {4'h0, sh1_q};
                    {sh2_d, sb2_d} = {4'h0, sh2_q};
                    {sh3_d, sb3_d} = {4'h0, sh3_q};
                    iss_d          = 1'b1;
                    cnt_d          = cnt_q + CW'(1);
                end
`endif
            end
            DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    st_d   = DONE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    drn_d = drn_q + DW'(1);
                end
            end
            DONE:    st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // Each issued nibble carries its index down a SBOX_LAT-deep tag line so the
    // stage result lands back in the position it came from.
    genvar gi;
    for (gi = 0; gi < SBOX_LAT; gi++) begin : g_tag
        if (gi == 0) begin : g_head
            assign tag_vld_d[gi] = iss_q;
            assign tag_idx_d[gi] = cnt_q;
        end else begin : g_body
            assign tag_vld_d[gi] = tag_vld_q[gi-1];
            assign tag_idx_d[gi] = tag_idx_q[gi-1];
        end
    end

    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
        logic wr;
        assign wr = tag_vld_q[SBOX_LAT-1] && (tag_idx_q[SBOX_LAT-1] == CW'(gi));
        assign out1_d[4*gi +: 4] = wr ? bus.sb_out1 : out1_q[4*gi +: 4];
        assign out2_d[4*gi +: 4] = wr ? bus.sb_out2 : out2_q[4*gi +: 4];
        assign out3_d[4*gi +: 4] = wr ? bus.sb_out3 : out3_q[4*gi +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            sh1_q  <= '0;
            sh2_q  <= '0;
            sh3_q  <= '0;
            sb1_q  <= '0;
            sb2_q  <= '0;
            sb3_q  <= '0;
            iss_q  <= 1'b0;
            cnt_q  <= '0;
            drn_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            out1_q <= '0;
            out2_q <= '0;
            out3_q <= '0;
            for (int i = 0; i < SBOX_LAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
            end
`ifdef SBOX_BUBBLE_EN
            ph_q   <= 1'b0;
`endif
        end else begin
            st_q      <= st_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
            sh3_q     <= sh3_d;
            sb1_q     <= sb1_d;
            sb2_q     <= sb2_d;
            sb3_q     <= sb3_d;
            iss_q     <= iss_d;
            cnt_q     <= cnt_d;
            drn_q     <= drn_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
            out3_q    <= out3_d;
            tag_vld_q <= tag_vld_d;
            tag_idx_q <= tag_idx_d;
`ifdef SBOX_BUBBLE_EN
            ph_q      <= ph_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.state1_out = out1_q;
    assign bus.state2_out = out2_q;
    assign bus.state3_out = out3_q;
    assign bus.sb_in1     = sb1_q;
    assign bus.sb_in2     = sb2_q;
    assign bus.sb_in3     = sb3_q;
    // The stage latches or remasks in exactly the busy window, so rnd_req tracks it.
    assign bus.rnd_req    = busy_q;
    assign bus.sb_rnd     = bus.rnd_in;
endmodule
